// File: rtl/psr_flag_unit_pkg.sv
// Shared definitions for the status-register stage: opcode and condition
// encodings, flag bit positions and the opcode class decode.
package psr_pkg;

   localparam logic [4:0] OPC_AND  = 5'd0;
   localparam logic [4:0] OPC_EOR  = 5'd1;
   localparam logic [4:0] OPC_SUB  = 5'd2;
   localparam logic [4:0] OPC_RSB  = 5'd3;
   localparam logic [4:0] OPC_ADD  = 5'd4;
   localparam logic [4:0] OPC_ADC  = 5'd5;
   localparam logic [4:0] OPC_SBC  = 5'd6;
   localparam logic [4:0] OPC_RSC  = 5'd7;
   localparam logic [4:0] OPC_TST  = 5'd8;
   localparam logic [4:0] OPC_TEQ  = 5'd9;
   localparam logic [4:0] OPC_CMP  = 5'd10;
   localparam logic [4:0] OPC_CMN  = 5'd11;
   localparam logic [4:0] OPC_ORR  = 5'd12;
   localparam logic [4:0] OPC_MOV  = 5'd13;
   localparam logic [4:0] OPC_BIC  = 5'd14;
   localparam logic [4:0] OPC_MVN  = 5'd15;
   localparam logic [4:0] OPC_AMB0 = 5'd16;
   localparam logic [4:0] OPC_AMB1 = 5'd17;
   localparam logic [4:0] OPC_AMB2 = 5'd18;
   localparam logic [4:0] OPC_AMB3 = 5'd19;
   localparam logic [4:0] OPC_AMB4 = 5'd20;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int unsigned F_N = 3;
   localparam int unsigned F_Z = 2;
   localparam int unsigned F_C = 1;
   localparam int unsigned F_V = 0;

   typedef enum logic [1:0] {
      CLS_LOGIC,
      CLS_ARITH,
      CLS_ADDR,
      CLS_NONE
   } opc_class_e;

   // Unlisted opcodes fall into CLS_NONE and simply never touch the flags.
   function automatic opc_class_e opc_class(input logic [4:0] op);
      case (op)
         OPC_AND, OPC_EOR, OPC_TST, OPC_TEQ,
         OPC_ORR, OPC_MOV, OPC_BIC, OPC_MVN:   return CLS_LOGIC;
         OPC_SUB, OPC_RSB, OPC_ADD, OPC_ADC,
         OPC_SBC, OPC_RSC, OPC_CMP, OPC_CMN:   return CLS_ARITH;
         OPC_AMB0, OPC_AMB1, OPC_AMB2,
         OPC_AMB3, OPC_AMB4:                   return CLS_ADDR;
         default:                              return CLS_NONE;
      endcase
   endfunction

endpackage

// File: rtl/psr_flag_unit_if.sv
// ALU-side bundle into the status-register stage and its registered results.
interface psr_flag_unit_if #(parameter int OPC_W = 5);
   logic             alu_valid;
   logic [OPC_W-1:0] alu_opcode;
   logic             s_bit;
   logic             alu_n;
   logic             alu_z;
   logic             alu_c;
   logic             alu_v;
   logic             shifter_c;
   logic [3:0]       cond;
   logic             cond_valid;
   logic             stall;
   logic [3:0]       flags_q;
   logic             carry_to_alu;
   logic             cond_pass;
   logic             cond_vld_q;

   modport master (
      output alu_valid, alu_opcode, s_bit, alu_n, alu_z, alu_c, alu_v,
             shifter_c, cond, cond_valid, stall,
      input  flags_q, carry_to_alu, cond_pass, cond_vld_q
   );

   modport slave (
      input  alu_valid, alu_opcode, s_bit, alu_n, alu_z, alu_c, alu_v,
             shifter_c, cond, cond_valid, stall,
      output flags_q, carry_to_alu, cond_pass, cond_vld_q
   );
endinterface

// File: rtl/psr_flag_unit_cond_eval.sv
// Combinational ARM condition-code check; also used by the branch unit.
module cond_eval
   import psr_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] flags_i,
   output logic       pass_o
);

   logic n, z, c, v;

   // Table lookup of the condition field against {N,Z,C,V}.
   always_comb begin
      n = flags_i[F_N];
      z = flags_i[F_Z];
      c = flags_i[F_C];
      v = flags_i[F_V];
      pass_o = 1'b0;
      case (cond_i)
         COND_EQ: pass_o = z;
         COND_NE: pass_o = ~z;
         COND_CS: pass_o = c;
         COND_CC: pass_o = ~c;
         COND_MI: pass_o = n;
         COND_PL: pass_o = ~n;
         COND_VS: pass_o = v;
         COND_VC: pass_o = ~v;
         COND_HI: pass_o = c & ~z;
         COND_LS: pass_o = ~c | z;
         COND_GE: pass_o = (n == v);
         COND_LT: pass_o = (n != v);
         COND_GT: pass_o = ~z & (n == v);
         COND_LE: pass_o = z | (n != v);
         COND_AL: pass_o = 1'b1;
         COND_NV: pass_o = 1'b0;
         default: pass_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/psr_flag_unit.sv
// Status-register stage behind the ALU: class-based flag latching and a
// registered condition-code evaluation result.
module psr_flag_unit
   import psr_pkg::*;
#(
   parameter bit BYPASS = 1'b1,
   parameter int OPC_W  = 5
) (
   input logic              clk,
   input logic              reset_n,
   psr_flag_unit_if.slave   bus
);

   logic [OPC_W-1:0] opc;
   logic [31:0]      opc_ext;
   opc_class_e       cls;
   logic             compare_op;
   logic             we;
   logic [3:0]       flags_d, flags_q;
   logic [3:0]       eval_flags;
   logic             pass_d, pass_q;
   logic             vld_d, vld_q;

   assign opc     = bus.alu_opcode;
   assign opc_ext = 32'(opc);

   // Class decode, write enable and next flag value.
   always_comb begin
      cls        = (opc_ext[31:5] == '0) ? opc_class(opc_ext[4:0]) : CLS_NONE;
      // TST/TEQ/CMP/CMN (8..11) share opc_ext[31:2] == 2.
      compare_op = (opc_ext[31:2] == 30'd2);
      we         = bus.alu_valid & ~bus.stall & (bus.s_bit | compare_op) &
                   ((cls == CLS_LOGIC) | (cls == CLS_ARITH));
      flags_d    = flags_q;
      case (cls)
         CLS_LOGIC: flags_d = {bus.alu_n, bus.alu_z, bus.shifter_c, flags_q[F_V]};
         CLS_ARITH: flags_d = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
         default:   flags_d = flags_q;
      endcase
      eval_flags = (BYPASS && we) ? flags_d : flags_q;
      vld_d      = bus.cond_valid & ~bus.stall;
   end

   cond_eval u_cond_eval (
      .cond_i  (bus.cond),
      .flags_i (eval_flags),
      .pass_o  (pass_d)
   );

   // Flag register and registered evaluation result; stall freezes state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_q <= '0;
         pass_q  <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         if (we) flags_q <= flags_d;
         if (vld_d) pass_q <= pass_d;
         vld_q <= vld_d;
      end
   end

   assign bus.flags_q      = flags_q;
   assign bus.carry_to_alu = flags_q[F_C];
   assign bus.cond_pass    = pass_q;
   assign bus.cond_vld_q   = vld_q;

endmodule

// File: tb/tb_psr_flag_unit.sv
// Scoreboard bench for psr_flag_unit: BYPASS=1 and BYPASS=0 instances run
// the same stimulus against an independent flag/condition model.
module tb_psr_flag_unit;

   typedef struct packed {
      logic [3:0] f;
      logic       c;
      logic       p;
      logic       v;
   } out_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   psr_flag_unit_if #(.OPC_W(5)) bus1 ();
   psr_flag_unit_if #(.OPC_W(5)) bus0 ();

   psr_flag_unit #(.BYPASS(1'b1), .OPC_W(5)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));
   psr_flag_unit #(.BYPASS(1'b0), .OPC_W(5)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));

   int total = 0;
   int bad   = 0;

   out_t exp1_q[$], exp0_q[$], obs1_q[$], obs0_q[$];
   logic [3:0] m_flags = 4'b0000;
   logic       m_p1 = 1'b0;
   logic       m_p0 = 1'b0;

   function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n ~^ v;
         4'd11: return n ^ v;
         4'd12: return !z && (n ~^ v);
         4'd13: return z || (n ^ v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic out_t snap1();
      return '{bus1.flags_q, bus1.carry_to_alu, bus1.cond_pass, bus1.cond_vld_q};
   endfunction

   function automatic out_t snap0();
      return '{bus0.flags_q, bus0.carry_to_alu, bus0.cond_pass, bus0.cond_vld_q};
   endfunction

   task automatic drive_if(input logic v, input logic [4:0] op, input logic s,
                           input logic [3:0] af, input logic sc, input logic [3:0] c,
                           input logic cv, input logic st);
      bus1.alu_valid = v;  bus0.alu_valid = v;
      bus1.alu_opcode = op; bus0.alu_opcode = op;
      bus1.s_bit = s;      bus0.s_bit = s;
      {bus1.alu_n, bus1.alu_z, bus1.alu_c, bus1.alu_v} = af;
      {bus0.alu_n, bus0.alu_z, bus0.alu_c, bus0.alu_v} = af;
      bus1.shifter_c = sc; bus0.shifter_c = sc;
      bus1.cond = c;       bus0.cond = c;
      bus1.cond_valid = cv; bus0.cond_valid = cv;
      bus1.stall = st;     bus0.stall = st;
   endtask

   // One clock: drive, push model expectation, sample 1 time unit after the edge.
   task automatic cycle(input logic v, input logic [4:0] op, input logic s,
                        input logic [3:0] af, input logic sc, input logic [3:0] c,
                        input logic cv, input logic st);
      logic is_log, is_ari, we, vld;
      logic [3:0] nf;
      drive_if(v, op, s, af, sc, c, cv, st);
      is_log = op inside {5'd0, 5'd1, 5'd8, 5'd9, 5'd12, 5'd13, 5'd14, 5'd15};
      is_ari = op inside {[5'd2:5'd7], 5'd10, 5'd11};
      we  = v && !st && (s || (op inside {[5'd8:5'd11]})) && (is_log || is_ari);
      nf  = is_ari ? af : (is_log ? {af[3], af[2], sc, m_flags[0]} : m_flags);
      vld = cv && !st;
      if (vld) begin
         m_p1 = cond_ref(c, we ? nf : m_flags);
         m_p0 = cond_ref(c, m_flags);
      end
      if (we) m_flags = nf;
      exp1_q.push_back('{m_flags, m_flags[1], m_p1, vld});
      exp0_q.push_back('{m_flags, m_flags[1], m_p0, vld});
      @(posedge clk);
      #1;
      obs1_q.push_back(snap1());
      obs0_q.push_back(snap0());
   endtask

   task automatic model_reset();
      m_flags = 4'b0000;
      m_p1 = 1'b0;
      m_p0 = 1'b0;
      exp1_q.delete(); exp0_q.delete(); obs1_q.delete(); obs0_q.delete();
   endtask

   task automatic test_reset();
      out_t z = '0;
      drive_if(0, 5'd0, 0, 4'h0, 0, 4'h0, 0, 0);
      #12;
      total += 2;
      if (snap1() !== z) begin bad++; $display("FAIL reset byp1 got=%b exp=%b", snap1(), z); end
      if (snap0() !== z) begin bad++; $display("FAIL reset byp0 got=%b exp=%b", snap0(), z); end
      reset_n = 1'b1;
      model_reset();
      cycle(0, 5'd0, 0, 4'h0, 0, 4'h0, 0, 0);
      while (exp1_q.size() != 0) begin
         out_t e1 = exp1_q.pop_front(), o1 = obs1_q.pop_front();
         out_t e0 = exp0_q.pop_front(), o0 = obs0_q.pop_front();
         total += 2;
         if (o1 !== e1) begin bad++; $display("FAIL reset_idle byp1 got=%b exp=%b", o1, e1); end
         if (o0 !== e0) begin bad++; $display("FAIL reset_idle byp0 got=%b exp=%b", o0, e0); end
      end
   endtask

   task automatic test_arith_sub();
      cycle(1, 5'd2, 1, 4'b1000, 0, 4'hB, 1, 0);
      cycle(0, 5'd0, 0, 4'h0, 0, 4'h0, 0, 0);
      while (exp1_q.size() != 0) begin
         out_t e1 = exp1_q.pop_front(), o1 = obs1_q.pop_front();
         out_t e0 = exp0_q.pop_front(), o0 = obs0_q.pop_front();
         total += 2;
         if (o1 !== e1) begin bad++; $display("FAIL arith_sub byp1 got=%b exp=%b", o1, e1); end
         if (o0 !== e0) begin bad++; $display("FAIL arith_sub byp0 got=%b exp=%b", o0, e0); end
      end
   endtask

   task automatic test_logic_and();
      cycle(1, 5'd4, 1, 4'b0001, 0, 4'h0, 0, 0);
      cycle(1, 5'd0, 1, 4'b0100, 1, 4'h0, 0, 0);
      cycle(0, 5'd0, 1, 4'b1111, 0, 4'h0, 0, 0);
      while (exp1_q.size() != 0) begin
         out_t e1 = exp1_q.pop_front(), o1 = obs1_q.pop_front();
         out_t e0 = exp0_q.pop_front(), o0 = obs0_q.pop_front();
         total += 2;
         if (o1 !== e1) begin bad++; $display("FAIL logic_and byp1 got=%b exp=%b", o1, e1); end
         if (o0 !== e0) begin bad++; $display("FAIL logic_and byp0 got=%b exp=%b", o0, e0); end
      end
   endtask

   task automatic test_cmp_add();
      cycle(1, 5'd10, 0, 4'b0110, 0, 4'h0, 0, 0);
      cycle(1, 5'd4,  0, 4'b1001, 0, 4'h0, 0, 0);
      cycle(1, 5'd8,  0, 4'b1000, 0, 4'h0, 0, 0);
      while (exp1_q.size() != 0) begin
         out_t e1 = exp1_q.pop_front(), o1 = obs1_q.pop_front();
         out_t e0 = exp0_q.pop_front(), o0 = obs0_q.pop_front();
         total += 2;
         if (o1 !== e1) begin bad++; $display("FAIL cmp_add byp1 got=%b exp=%b", o1, e1); end
         if (o0 !== e0) begin bad++; $display("FAIL cmp_add byp0 got=%b exp=%b", o0, e0); end
      end
   endtask

   task automatic test_addr();
      cycle(1, 5'd18, 1, 4'b1111, 1, 4'h0, 0, 0);
      cycle(1, 5'd25, 1, 4'b1111, 1, 4'h0, 0, 0);
      cycle(1, 5'd20, 1, 4'b0000, 0, 4'h0, 0, 0);
      while (exp1_q.size() != 0) begin
         out_t e1 = exp1_q.pop_front(), o1 = obs1_q.pop_front();
         out_t e0 = exp0_q.pop_front(), o0 = obs0_q.pop_front();
         total += 2;
         if (o1 !== e1) begin bad++; $display("FAIL addr_op byp1 got=%b exp=%b", o1, e1); end
         if (o0 !== e0) begin bad++; $display("FAIL addr_op byp0 got=%b exp=%b", o0, e0); end
      end
   endtask

   task automatic test_cond_sweep();
      for (int f = 0; f < 16; f++) begin
         cycle(1, 5'd4, 1, 4'(f), 0, 4'h0, 0, 0);
         for (int c = 0; c < 16; c++) cycle(0, 5'd0, 0, 4'h0, 0, 4'(c), 1, 0);
         while (exp1_q.size() != 0) begin
            out_t e1 = exp1_q.pop_front(), o1 = obs1_q.pop_front();
            out_t e0 = exp0_q.pop_front(), o0 = obs0_q.pop_front();
            total += 2;
            if (o1 !== e1) begin bad++; $display("FAIL sweep f=%0d byp1 got=%b exp=%b", f, o1, e1); end
            if (o0 !== e0) begin bad++; $display("FAIL sweep f=%0d byp0 got=%b exp=%b", f, o0, e0); end
         end
      end
   endtask

   task automatic test_stall();
      cycle(1, 5'd4, 1, 4'b0101, 0, 4'h6, 1, 0);
      for (int i = 0; i < 3; i++) cycle(1, 5'd4, 1, 4'b1010, 1, 4'h7, 1, 1);
      cycle(0, 5'd0, 0, 4'h0, 0, 4'h0, 0, 0);
      cycle(0, 5'd0, 0, 4'h0, 0, 4'h7, 1, 0);
      while (exp1_q.size() != 0) begin
         out_t e1 = exp1_q.pop_front(), o1 = obs1_q.pop_front();
         out_t e0 = exp0_q.pop_front(), o0 = obs0_q.pop_front();
         total += 2;
         if (o1 !== e1) begin bad++; $display("FAIL stall byp1 got=%b exp=%b", o1, e1); end
         if (o0 !== e0) begin bad++; $display("FAIL stall byp0 got=%b exp=%b", o0, e0); end
      end
   endtask

   task automatic test_bypass0();
      cycle(1, 5'd4, 1, 4'b0000, 0, 4'h0, 0, 0);
      cycle(1, 5'd4, 1, 4'b0100, 0, 4'h0, 1, 0);
      cycle(1, 5'd2, 1, 4'b1001, 0, 4'hC, 1, 0);
      while (exp1_q.size() != 0) begin
         out_t e1 = exp1_q.pop_front(), o1 = obs1_q.pop_front();
         out_t e0 = exp0_q.pop_front(), o0 = obs0_q.pop_front();
         total += 2;
         if (o1 !== e1) begin bad++; $display("FAIL bypass byp1 got=%b exp=%b", o1, e1); end
         if (o0 !== e0) begin bad++; $display("FAIL bypass byp0 got=%b exp=%b", o0, e0); end
      end
   endtask

   task automatic test_async_reset();
      out_t z = '0;
      cycle(1, 5'd4, 1, 4'b1111, 0, 4'hE, 1, 0);
      while (exp1_q.size() != 0) begin
         out_t e1 = exp1_q.pop_front(), o1 = obs1_q.pop_front();
         out_t e0 = exp0_q.pop_front(), o0 = obs0_q.pop_front();
         total += 2;
         if (o1 !== e1) begin bad++; $display("FAIL preset byp1 got=%b exp=%b", o1, e1); end
         if (o0 !== e0) begin bad++; $display("FAIL preset byp0 got=%b exp=%b", o0, e0); end
      end
      #2;
      reset_n = 1'b0;
      #1;
      total += 2;
      if (snap1() !== z) begin bad++; $display("FAIL async_reset byp1 got=%b exp=%b", snap1(), z); end
      if (snap0() !== z) begin bad++; $display("FAIL async_reset byp0 got=%b exp=%b", snap0(), z); end
      #1;
      reset_n = 1'b1;
      model_reset();
      cycle(0, 5'd0, 0, 4'h0, 0, 4'h0, 1, 0);
      cycle(1, 5'd2, 1, 4'b0010, 0, 4'h2, 1, 0);
      while (exp1_q.size() != 0) begin
         out_t e1 = exp1_q.pop_front(), o1 = obs1_q.pop_front();
         out_t e0 = exp0_q.pop_front(), o0 = obs0_q.pop_front();
         total += 2;
         if (o1 !== e1) begin bad++; $display("FAIL post_reset byp1 got=%b exp=%b", o1, e1); end
         if (o0 !== e0) begin bad++; $display("FAIL post_reset byp0 got=%b exp=%b", o0, e0); end
      end
   endtask

   initial begin
      test_reset();
      test_arith_sub();
      test_logic_and();
      test_cmp_add();
      test_addr();
      test_cond_sweep();
      test_stall();
      test_bypass0();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
